// File: rtl/uart_rx_pkg.sv
// Shared types, constants and the baud divisor helper for the UART receive path.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam int unsigned SAMPLE_PHASE = 8;
  localparam int unsigned BAUD_9600    = 9600;
  localparam int unsigned BAUD_115200  = 115200;
  localparam int unsigned DIV_W        = 16;
  localparam int unsigned PHASE_W      = 4;

  // Clocks per oversample tick, rounded to nearest.
  function automatic logic [DIV_W-1:0] baud_div(input longint unsigned clk_hz,
                                                input longint unsigned baud);
    longint unsigned num;
    num = (clk_hz + (baud * 64'd8)) / (baud * 64'(OVERSAMPLE));
    return DIV_W'(num);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator with two selectable baud divisors and a restart input.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic i_rx_clk,
  input  logic i_rx_rst_n,
  input  logic baud_sel,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_W-1:0] DIV_FAST = baud_div(64'(CLK_FREQ_HZ), 64'(BAUD_115200));
  localparam logic [DIV_W-1:0] DIV_SLOW = baud_div(64'(CLK_FREQ_HZ), 64'(BAUD_9600));

  logic [DIV_W-1:0] div_c;
  logic [DIV_W-1:0] cnt_q;

  assign div_c = baud_sel ? DIV_SLOW : DIV_FAST;

  // Reload counter; tick is registered and lasts one cycle.
  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (restart) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q >= div_c - DIV_W'(1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with 16x oversampling, two run-time baud rates and
// start-of-frame marking after a line-idle gap.
module uart_rx_framer
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned IDLE_BITS   = 20
) (
  input  logic        i_rx_clk,
  input  logic        i_rx_rst_n,
  input  logic        i_rx_serial,
  input  logic        i_baud_sel,
  output logic [31:0] o_rx_data,
  output logic        o_rx_data_valid,
  output logic        o_rx_sof,
  output logic        o_frame_err,
  output logic        o_rx_busy
);

  localparam int unsigned GAP_MAX = IDLE_BITS * OVERSAMPLE;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX + 1);

  rx_state_e          state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, phase_inc_c;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         data_q, data_d;
  logic               valid_q, valid_d;
  logic               sof_q, sof_d;
  logic               ferr_q, ferr_d;
  logic               busy_q, busy_d;
  logic               arm_q, arm_d;
  logic               pend_q, pend_d;
  logic [GAP_W-1:0]   gap_q, gap_d;

  logic rx_meta, rx_sync, rx_prev;
  logic baud_act;
  logic tick;
  logic fall_c, restart_c, sample_c;

  // Line synchronizer plus one delayed copy for edge detection; idle-high reset.
  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx_serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall_c = rx_prev & ~rx_sync;

  // Baud selection only follows the input between frames.
  assign restart_c = (state_q == IDLE) && (i_baud_sel != baud_act);

  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      baud_act <= 1'b0;
    end else if (state_q == IDLE) begin
      baud_act <= i_baud_sel;
    end
  end

  uart_baud_tick #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_tick (
    .i_rx_clk  (i_rx_clk),
    .i_rx_rst_n(i_rx_rst_n),
    .baud_sel  (baud_act),
    .restart   (restart_c),
    .tick      (tick)
  );

  assign phase_inc_c = phase_q + PHASE_W'(1);
  assign sample_c    = tick && (phase_inc_c == PHASE_W'(SAMPLE_PHASE));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    ferr_d  = 1'b0;
    arm_d   = arm_q;
    pend_d  = 1'b0;
    gap_d   = '0;

    if (tick && (state_q != IDLE)) phase_d = phase_inc_c;

    case (state_q)
      IDLE: begin
        if (rx_sync) begin
          gap_d = (tick && (gap_q != GAP_W'(GAP_MAX))) ? gap_q + GAP_W'(1) : gap_q;
        end
        if (gap_q == GAP_W'(GAP_MAX)) arm_d = 1'b1;
        // A fall seen on the cycle we re-entered IDLE is honoured one cycle late.
        if (fall_c || pend_q) begin
          state_d = START;
          phase_d = '0;
          gap_d   = '0;
        end
      end
      START: begin
        if (sample_c) begin
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (sample_c) begin
          shift_d = {rx_sync, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a slightly fast sender's next start edge is caught.
        if (sample_c) begin
          state_d = IDLE;
          arm_d   = 1'b0;
          pend_d  = fall_c;
          if (rx_sync) begin
            valid_d = 1'b1;
            data_d  = shift_q;
            sof_d   = arm_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_rx_clk or negedge i_rx_rst_n) begin
    if (!i_rx_rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
      arm_q   <= 1'b0;
      pend_q  <= 1'b0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
      arm_q   <= arm_d;
      pend_q  <= pend_d;
      gap_q   <= gap_d;
    end
  end

  assign o_rx_data       = 32'(data_q);
  assign o_rx_data_valid = valid_q;
  assign o_rx_sof        = sof_q;
  assign o_frame_err     = ferr_q;
  assign o_rx_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Scoreboard bench for uart_rx_framer: a line driver pushes expected bytes,
// a negedge monitor pops and compares whenever the DUT strobes.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int unsigned CLK_HZ    = 5_000_000;
  localparam int unsigned IDLE_BITS = 20;
  localparam int unsigned DIV_FAST  = (CLK_HZ + 8 * 115200) / (16 * 115200);
  localparam int unsigned DIV_SLOW  = (CLK_HZ + 8 * 9600) / (16 * 9600);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        serial = 1'b1;
  logic        baud_sel = 1'b0;
  logic [31:0] o_rx_data;
  logic        o_rx_data_valid, o_rx_sof, o_frame_err, o_rx_busy;

  typedef struct {
    bit          is_err;
    logic [7:0]  data;
    bit          sof;
    longint      t_start;
    int unsigned div;
  } exp_t;

  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;
  bit     armed = 1'b0;
  int     gap_bits = 0;

  uart_rx_framer #(
    .CLK_FREQ_HZ(CLK_HZ),
    .IDLE_BITS  (IDLE_BITS)
  ) dut (
    .i_rx_clk       (clk),
    .i_rx_rst_n     (rst_n),
    .i_rx_serial    (serial),
    .i_baud_sel     (baud_sel),
    .o_rx_data      (o_rx_data),
    .o_rx_data_valid(o_rx_data_valid),
    .o_rx_sof       (o_rx_sof),
    .o_frame_err    (o_frame_err),
    .o_rx_busy      (o_rx_busy)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Reference rule: a high gap of at least IDLE_BITS bit times arms SOF.
  task automatic idle(input int bits, input int unsigned div);
    serial = 1'b1;
    wait_cycles(bits * 16 * div);
    gap_bits += bits;
    if (gap_bits >= IDLE_BITS) armed = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned div, input bit stop_ok);
    exp_t        e;
    int unsigned bit_cyc;
    bit_cyc   = 16 * div;
    e.is_err  = !stop_ok;
    e.data    = b;
    e.sof     = stop_ok ? armed : 1'b0;
    e.t_start = cyc;
    e.div     = div;
    armed     = 1'b0;
    q.push_back(e);
    serial = 1'b0;
    wait_cycles(bit_cyc);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      wait_cycles(bit_cyc);
    end
    serial = stop_ok;
    wait_cycles(bit_cyc);
    serial   = 1'b1;
    gap_bits = 0;
  endtask

  // Monitor: pop and compare on every strobe.
  always @(negedge clk) begin
    exp_t   e;
    longint lat, lo, hi;
    if (o_rx_sof && !o_rx_data_valid) begin
      tests++;
      fails++;
      $display("FAIL sof_without_valid: sof=1 valid=0 at cycle %0d", cyc);
    end
    if (o_rx_data_valid || o_frame_err) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%0h, nothing expected", o_rx_data_valid, o_frame_err, o_rx_data);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          chk("frame_err", 64'(o_frame_err), 1);
          chk("err_no_valid", 64'(o_rx_data_valid), 0);
        end else begin
          chk("valid", 64'(o_rx_data_valid), 1);
          chk("no_frame_err", 64'(o_frame_err), 0);
          chk("data", 64'(o_rx_data), 64'(e.data));
          chk("sof", 64'(o_rx_sof), 64'(e.sof));
          lat = cyc - e.t_start;
          lo  = 152 * longint'(e.div) - longint'(e.div);
          hi  = 152 * longint'(e.div) + 8;
          tests++;
          if (lat < lo || lat > hi) begin
            fails++;
            $display("FAIL latency: got %0d cycles expected %0d..%0d", lat, lo, hi);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    int         gap;
    bit         ok;

    // Reset state
    wait_cycles(5);
    chk("rst_data", 64'(o_rx_data), 0);
    chk("rst_valid", 64'(o_rx_data_valid), 0);
    chk("rst_sof", 64'(o_rx_sof), 0);
    chk("rst_ferr", 64'(o_frame_err), 0);
    chk("rst_busy", 64'(o_rx_busy), 0);
    rst_n = 1'b1;

    // 1: three bytes at 115200, SOF only on the first
    idle(25, DIV_FAST);
    send_byte(8'h55, DIV_FAST, 1'b1);
    idle(2, DIV_FAST);
    send_byte(8'h05, DIV_FAST, 1'b1);
    idle(2, DIV_FAST);
    send_byte(8'h00, DIV_FAST, 1'b1);

    // 2: one byte at 9600 with SOF
    baud_sel = 1'b1;
    idle(25, DIV_SLOW);
    send_byte(8'hAA, DIV_SLOW, 1'b1);
    baud_sel = 1'b0;
    idle(2, DIV_FAST);

    // 3: short glitch while idle
    serial = 1'b0;
    wait_cycles(3 * DIV_FAST);
    chk("glitch_busy_high", 64'(o_rx_busy), 1);
    serial   = 1'b1;
    gap_bits = 0;
    wait_cycles(20 * DIV_FAST);
    chk("glitch_busy_low", 64'(o_rx_busy), 0);

    // 4: framing error clears arming; short gap -> no SOF, long gap -> SOF
    idle(25, DIV_FAST);
    send_byte(8'h3C, DIV_FAST, 1'b0);
    idle(5, DIV_FAST);
    send_byte(8'hA5, DIV_FAST, 1'b1);
    idle(25, DIV_FAST);
    send_byte(8'h5A, DIV_FAST, 1'b1);

    // 5: baud change mid-byte applies to the following byte
    idle(3, DIV_FAST);
    fork
      send_byte(8'hC3, DIV_FAST, 1'b1);
      begin
        wait_cycles(5 * 16 * DIV_FAST);
        baud_sel = 1'b1;
      end
    join
    idle(3, DIV_SLOW);
    send_byte(8'h96, DIV_SLOW, 1'b1);
    baud_sel = 1'b0;
    idle(2, DIV_FAST);

    // 6: reset during data bit 4 of 0xF0
    serial = 1'b0;
    wait_cycles(5 * 16 * DIV_FAST);
    serial = 1'b1;
    wait_cycles(8 * DIV_FAST);
    chk("midbyte_busy", 64'(o_rx_busy), 1);
    rst_n = 1'b0;
    wait_cycles(3);
    chk("midrst_data", 64'(o_rx_data), 0);
    chk("midrst_busy", 64'(o_rx_busy), 0);
    chk("midrst_valid", 64'(o_rx_data_valid), 0);
    rst_n    = 1'b1;
    armed    = 1'b0;
    gap_bits = 0;
    idle(25, DIV_FAST);
    send_byte(8'h11, DIV_FAST, 1'b1);

    // Randomized traffic at 115200
    for (int n = 0; n < 12; n++) begin
      gap = ($urandom_range(1, 0) == 1) ? int'($urandom_range(4, 1)) : int'($urandom_range(26, 22));
      b   = 8'($urandom);
      ok  = ($urandom_range(5, 0) != 0);
      idle(gap, DIV_FAST);
      send_byte(b, DIV_FAST, ok);
    end

    idle(3, DIV_FAST);
    chk("queue_drained", longint'(q.size()), 0);
    chk("final_busy", 64'(o_rx_busy), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
# uart_rx_framer

Serial front end of the UART/VLC receive path. Recovers 8N1 bytes from the asynchronous line `i_rx_serial` using 16x oversampling at one of two run-time baud rates. It marks the first byte after a line-idle gap as start-of-frame and delivers bytes as single-cycle strobes in the `i_rx_clk` domain. Its outputs feed the RX interface's async FIFO write side, which consumes `i_rx_data[7:0]`, `i_rx_data_valid` and `i_rx_sof`.

## Interface

Parameters:
- `CLK_FREQ_HZ`, default 50_000_000: `i_rx_clk` frequency.
- `IDLE_BITS`, default 20: minimum line-high gap, in bit times, that arms SOF.

Ports (clock and reset first):
- `i_rx_clk`, in, 1: receive clock.
- `i_rx_rst_n`, in, 1: asynchronous active-low reset.
- `i_rx_serial`, in, 1: raw UART line, asynchronous; idles high.
- `i_baud_sel`, in, 1: 1 = 9600 baud, 0 = 115200 baud. Driven by the RX interface's baud-rate output through a synchronizer owned by the parent.
- `o_rx_data`, out, 32: received byte on [7:0]; [31:8] are always 0.
- `o_rx_data_valid`, out, 1: one-cycle strobe; `o_rx_data` is valid while it is high.
- `o_rx_sof`, out, 1: high only together with `o_rx_data_valid`, on the first byte after an idle gap.
- `o_frame_err`, out, 1: one-cycle pulse when a stop bit is sampled low.
- `o_rx_busy`, out, 1: high while the FSM is not in IDLE.

## Operation

- **Input sync.** 2-flop synchronizer on `i_rx_serial`; both flops reset to 1.
- **Tick generator.**
  - Divisor DIV = (CLK_FREQ_HZ + 8·baud) / (16·baud), integer arithmetic, rounded. At the defaults this gives DIV = 27 for 115200 and DIV = 326 for 9600.
  - `tick` pulses once every DIV cycles. The counter is 16 bits.
- **Baud select.** `i_baud_sel` is registered into the active selection only while in IDLE. A change restarts the divider. A change during a byte takes effect at the next IDLE.
- **FSM.** States are IDLE, START, DATA, STOP. A 4-bit phase counter counts ticks within a bit.
  - IDLE: a synced falling edge (1 to 0) moves to START and clears phase.
  - START: at phase 8, if the line is 0, go to DATA with bit index 0. If the line is 1 (glitch), return to IDLE with no output.
  - DATA: sample at phase 8 of each bit, LSB first, into a shift register. After bit index 7, go to STOP.
  - STOP: sample at phase 8.
    - Line = 1: the next cycle has `o_rx_data_valid` = 1 and `o_rx_data` = the byte.
    - Line = 0: the next cycle has `o_frame_err` = 1, no valid strobe, and SOF arming is cleared.
    - Either way, return to IDLE immediately at the mid-stop sample. This tolerates senders that are up to half a bit fast.
- **SOF arming.**
  - The gap counter counts ticks while in IDLE with the synced line = 1. It clears on any 0 or when leaving IDLE, and saturates at IDLE_BITS·16.
  - Reaching saturation sets `sof_arm`.
  - The next valid byte carries `o_rx_sof` = `sof_arm`, then `sof_arm` clears.
  - `sof_arm` resets to 0, so a line that is mid-frame at reset is not mistaken for a frame start.
- **No backpressure.** Overflow handling is the consumer's job.

## Timing

- **Reset values:** `o_rx_data` = 0, `o_rx_data_valid` = 0, `o_rx_sof` = 0, `o_frame_err` = 0, `o_rx_busy` = 0. FSM in IDLE, active baud = 115200.
- **Bit period** is 16·DIV cycles: 432 cycles at 115200, 5216 cycles at 9600.
- **Latency:** `o_rx_data_valid` asserts 1 cycle after the tick that samples the stop bit mid-point. From the falling start edge this is about 2 + 9.5·16·DIV cycles.
- **Outputs** are registered. `o_rx_data` holds its value until the next valid strobe.
- **Minimum spacing** between valid strobes is 9.5 bit times.
- **Simultaneous events:** a falling edge in the same cycle as a return to IDLE is taken on the next cycle; at most one cycle of phase error is accepted.
- **Reset mid-byte:** the partial byte is discarded and no strobe is issued.

## Structure

- Shared package `uart_rx_pkg`:
  - state enum (IDLE/START/DATA/STOP)
  - OVERSAMPLE = 16, SAMPLE_PHASE = 8
  - BAUD_9600 = 9600, BAUD_115200 = 115200
  - divisor function
- Sub-module `uart_baud_tick`: divisor mux, reload counter, `tick` output, restart input.
- The FSM, shift register and gap/SOF logic live in the top level.

## Test plan

1. After reset, 25 idle bit times, then bytes 0x55, 0x05, 0x00 at 115200 → 3 strobes with data 0x55, 0x05, 0x00; `o_rx_sof` = 1 only on 0x55.
2. `i_baud_sel` = 1, 25 idle bits, then 0xAA at 9600 → one strobe with 0xAA and SOF = 1, arriving 1 cycle after the stop mid-sample (about 49 550 cycles after the start edge).
3. Glitch low of 3·27 cycles while idle → no strobe, no `o_frame_err`, `o_rx_busy` returns to 0.
4. Byte 0x3C with stop bit forced to 0 → `o_frame_err` pulse, no valid strobe. The next byte after a 5-bit gap has SOF = 0; after a 25-bit gap it has SOF = 1.
5. Toggle `i_baud_sel` from 0 to 1 in the middle of byte 0xC3 → 0xC3 is received correctly at 115200; the next byte is decoded at 9600.
6. Assert reset during DATA bit 4 of 0xF0, release, 25 idle bits, then 0x11 → no strobe for 0xF0; 0x11 arrives with SOF = 1.
